// File: rtl/router_arb_merge.sv
// Two-input round-robin merge for the router output port.
// Each input is buffered in its own small FIFO; one registered output stage.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in0_data/valid/ready : requester 0 (horizontal path) handshake
//   in1_data/valid/ready : requester 1 (vertical path) handshake
//   out_data/valid/ready : merged output handshake (registered)
//   pkt_count            : saturating count of delivered packets

module router_arb_fifo #(
    parameter int PACK_WIDTH = 44,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [PACK_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [PACK_WIDTH-1:0] head,
    output logic                  not_empty,
    output logic                  full
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [PACK_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign full      = (count == FULL);

    // Explicit wrap keeps non-power-of-two depths inside the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

module router_arb_merge #(
    parameter int PACK_WIDTH = 44,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PACK_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [PACK_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    output logic [PACK_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    logic [PACK_WIDTH-1:0] head0;
    logic [PACK_WIDTH-1:0] head1;
    logic                  ne0;
    logic                  ne1;
    logic                  full0;
    logic                  full1;
    logic                  push0;
    logic                  push1;
    logic                  pop0;
    logic                  pop1;
    logic                  load_en;
    logic                  last_grant;

    // Ready looks only at registered occupancy, so a full FIFO
    // cannot take a push even on the edge it is popped.
    assign in0_ready = !reset && !full0;
    assign in1_ready = !reset && !full1;
    assign push0     = in0_valid && in0_ready;
    assign push1     = in1_valid && in1_ready;
    assign load_en   = !out_valid || out_ready;

    router_arb_fifo #(
        .PACK_WIDTH(PACK_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (in0_data),
        .pop       (pop0),
        .head      (head0),
        .not_empty (ne0),
        .full      (full0)
    );

    router_arb_fifo #(
        .PACK_WIDTH(PACK_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (in1_data),
        .pop       (pop1),
        .head      (head1),
        .not_empty (ne1),
        .full      (full1)
    );

    // last_grant=1 means input 1 was served last, so input 0 wins a tie.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (load_en) begin
            unique case (1'b1)
                (ne0 && ne1): begin
                    pop0 = last_grant;
                    pop1 = !last_grant;
                end
                (ne0 && !ne1): pop0 = 1'b1;
                (!ne0 && ne1): pop1 = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            last_grant <= 1'b1;
        end else if (load_en) begin
            if (pop0 || pop1) begin
                out_data   <= pop0 ? head0 : head1;
                out_valid  <= 1'b1;
                last_grant <= pop1;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pkt_count <= '0;
        else if (out_valid && out_ready && pkt_count != {CNT_WIDTH{1'b1}})
            pkt_count <= pkt_count + 1'b1;
    end

endmodule

// File: doc/router_arb_merge.md
ROUTER_ARB_MERGE -- requirements
Module: router_arb_merge

Interface
REQ-001 SHALL have parameter PACK_WIDTH, default 44: packet width in bits; bits [43:40] are the destination address and pass through unmodified.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: entries per input buffer, legal values 2..8.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the forwarded-packet counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in0_data, input, PACK_WIDTH: packet from requester 0 (router left/horizontal path).
REQ-007 SHALL have port in0_valid, input, 1: in0_data holds a packet.
REQ-008 SHALL have port in0_ready, output, 1: the input 0 buffer can accept a packet.
REQ-009 SHALL have ports in1_data, in1_valid and in1_ready, with the same widths and meaning as the input 0 ports, for requester 1 (vertical path).
REQ-010 SHALL have port out_data, output, PACK_WIDTH: the granted packet.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a packet.
REQ-012 SHALL have port out_ready, input, 1: the downstream sink accepts this cycle.
REQ-013 SHALL have port pkt_count, output, CNT_WIDTH: number of packets delivered on the output.

Function
REQ-014 A transfer on any port SHALL occur exactly at a rising clk edge where valid and ready are both 1.
REQ-015 Each input SHALL push into its own FIFO_DEPTH-entry FIFO; order within an input is preserved.
REQ-016 inN_ready SHALL be 1 iff reset is 0 and FIFO N is not full; it SHALL be derived from registered occupancy only and SHALL NOT depend on out_ready or inN_valid.
REQ-017 The output SHALL be a single register stage with load_en = !out_valid || out_ready.
REQ-018 On load_en with exactly one FIFO non-empty, that FIFO's head SHALL be popped into out_data and out_valid SHALL be set to 1.
REQ-019 On load_en with both FIFOs non-empty, the input not granted last SHALL win (round-robin); last_grant SHALL then be updated to the winner.
REQ-020 On load_en with both FIFOs empty, out_valid SHALL go to 0 and out_data SHALL hold its value.
REQ-021 When out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable, and no pop SHALL occur.
REQ-022 Minimum latency SHALL be: input transfer at edge N, out_valid=1 with that packet after edge N+1.
REQ-023 Sustained throughput SHALL be one packet per cycle when out_ready is held at 1.
REQ-024 A push and a pop on the same FIFO at the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-025 A FIFO that is full SHALL NOT accept a push in a cycle even if it is popped at the same edge; its ready rises one cycle later.
REQ-026 pkt_count SHALL increment by 1 at each output transfer and saturate at all-ones with no wrap.
REQ-027 Packet contents SHALL NOT be altered; no packet SHALL be dropped or duplicated outside reset.
REQ-028 Pointer and occupancy arithmetic SHALL wrap modulo FIFO_DEPTH with no overflow for non-power-of-two depths.

Reset
REQ-029 While reset=1: both FIFOs SHALL be empty, out_valid=0, out_data=0, pkt_count=0, last_grant=1 (so input 0 wins the first tie), and in0_ready=in1_ready=0.
REQ-030 Assertion of reset mid-operation SHALL discard all buffered and in-flight packets immediately, with no partial transfer.
REQ-031 After reset deasserts, both inN_ready SHALL be 1 in the first cycle.

Verification
REQ-032 Single packet: in0 sends 0x1_00000000AB at edge 1, out_ready=1 -> out_valid=1 with that data after edge 2; pkt_count=1 after edge 3.
REQ-033 Tie: both FIFOs hold 3 packets (A0-A2 on input 0, B0-B2 on input 1), out_ready=1 -> output order A0,B0,A1,B1,A2,B2; pkt_count=6.
REQ-034 Backpressure: out_ready=0 for 10 cycles while in0 streams -> out_data frozen; in0_ready=0 after FIFO_DEPTH packets are buffered (plus one in out_data); out_ready=1 -> all packets emerge in order, none lost.
REQ-035 Full FIFO with simultaneous pop: in0 FIFO full, pop occurs while in0_valid=1 -> no push that edge; in0_ready=1 the next cycle.
REQ-036 Reset mid-stream: reset asserted with 2 packets buffered -> out_valid=0 and pkt_count=0 immediately; after deassert, the first packet out is a newly sent one.
REQ-037 Counter saturation: CNT_WIDTH=4, 20 packets sent -> pkt_count holds 4'hF.
